rob_param: RTL

- Parametrised in-order-retire reorder buffer for the out-of-order RISC-V core.
- Sits between rename/dispatch (allocation), functional-unit writeback (completion) and architectural commit (retirement).
- Generalises the fixed 16-entry, 2-dispatch, 3-complete, 2-retire ROB with:
  - head/tail ring pointers and full/empty tracking,
  - ROB-index return to dispatch,
  - strictly in-order contiguous retirement,
  - a flush mode.

---
 rtl/rob_param_pkg.sv | 24 ++
 rtl/rob_param_retire_select.sv | 32 +++
 rtl/rob_param.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rob_param_pkg.sv
// Shared types for the reorder buffer: dispatch payload and stored entry.
package rob_param_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int unsigned ROB_DATA_W = 32;
  localparam int unsigned ROB_PREG_W = 6;

  typedef struct packed {
    logic [ROB_PREG_W-1:0] PRegAddrDst;
    logic [ROB_PREG_W-1:0] OldPRegAddrDst;
    logic                  RegWrite;
    logic                  MemWrite;
    logic                  MemtoReg;
  } rob_alloc_t;

  typedef struct packed {
    rob_alloc_t            alloc;
    logic                  valid;
    logic                  complete;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_param_retire_select.sv
// Combinational scan from head: counts the leading run of valid+complete entries.
module rob_retire_select #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned RETIRE_W = 2
) (
  input  logic [DEPTH-1:0]                           i_valid,
  input  logic [DEPTH-1:0]                           i_complete,
  input  logic [$clog2(DEPTH)-1:0]                   i_head,
  output logic [$clog2(RETIRE_W+1)-1:0]              o_count,
  output logic [RETIRE_W-1:0][$clog2(DEPTH)-1:0]     o_idx
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(RETIRE_W+1);

  logic run;

  always_comb begin
    o_count = '0;
    o_idx   = '0;
    run     = 1'b1;
    for (int unsigned k = 0; k < RETIRE_W; k++) begin
      o_idx[k] = i_head + IDX_W'(k);
      if (run && i_valid[o_idx[k]] && i_complete[o_idx[k]]) begin
        o_count = o_count + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_param.sv
// In-order-retire reorder buffer with wrap-bit ring pointers and flush.
module rob_param
  import rob_param_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DISPATCH_W = 2,
  parameter int unsigned COMPLETE_W = 3,
  parameter int unsigned RETIRE_W   = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PREG_W     = 6
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic [DISPATCH_W-1:0]                     i_alloc_valid,
  input  rob_alloc_t [DISPATCH_W-1:0]               i_alloc_entry,
  output logic                                      o_alloc_ready,
  output logic [DISPATCH_W-1:0][$clog2(DEPTH)-1:0]  o_alloc_idx,
  input  logic [COMPLETE_W-1:0]                     i_cmpl_valid,
  input  logic [COMPLETE_W-1:0][$clog2(DEPTH)-1:0]  i_cmpl_idx,
  input  logic [COMPLETE_W-1:0][DATA_W-1:0]         i_cmpl_data,
  output logic [RETIRE_W-1:0]                       o_retire_valid,
  output rob_entry_t [RETIRE_W-1:0]                 o_retire_entry,
  input  logic                                      i_flush,
  output logic [$clog2(DEPTH):0]                    o_count,
  output logic                                      o_full,
  output logic                                      o_empty
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned RCNT_W = $clog2(RETIRE_W+1);

  if (DATA_W != ROB_DATA_W || PREG_W != ROB_PREG_W || DEPTH < 4 || (1 << IDX_W) != DEPTH)
  begin : g_bad_param
    $error("rob_param: DATA_W/PREG_W must match rob_param_pkg and DEPTH must be a power of two >= 4");
  end

  rob_entry_t [DEPTH-1:0]    entries_q, entries_d;
  logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
  logic [RETIRE_W-1:0]       retire_valid_q, retire_valid_d;
  rob_entry_t [RETIRE_W-1:0] retire_entry_q, retire_entry_d;

  logic [DEPTH-1:0]                 valid_vec, complete_vec;
  logic [RCNT_W-1:0]                ret_cnt;
  logic [RETIRE_W-1:0][IDX_W-1:0]   ret_idx;
  logic [PTR_W-1:0]                 count, free_cnt, alloc_cnt;

  assign count         = tail_q - head_q;
  assign free_cnt      = PTR_W'(DEPTH) - count;
  assign o_count       = count;
  assign o_empty       = (head_q == tail_q);
  assign o_full        = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign o_alloc_ready = 32'(free_cnt) >= DISPATCH_W;
  assign o_retire_valid = retire_valid_q;
  assign o_retire_entry = retire_entry_q;

  always_comb begin
    alloc_cnt   = '0;
    o_alloc_idx = '0;
    for (int unsigned k = 0; k < DISPATCH_W; k++) begin
      o_alloc_idx[k] = tail_q[IDX_W-1:0] + alloc_cnt[IDX_W-1:0];
      if (i_alloc_valid[k]) alloc_cnt = alloc_cnt + PTR_W'(1);
    end
  end

  always_comb begin
    valid_vec    = '0;
    complete_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_vec[i]    = entries_q[i].valid;
      complete_vec[i] = entries_q[i].complete;
    end
  end

  rob_retire_select #(
    .DEPTH    (DEPTH),
    .RETIRE_W (RETIRE_W)
  ) u_retire_select (
    .i_valid    (valid_vec),
    .i_complete (complete_vec),
    .i_head     (head_q[IDX_W-1:0]),
    .o_count    (ret_cnt),
    .o_idx      (ret_idx)
  );

  // Update order: completions, then retire clears, then allocation writes.
  // Allocation only ever targets currently-invalid slots, so these never collide.
  always_comb begin
    entries_d      = entries_q;
    head_d         = head_q;
    tail_d         = tail_q;
    retire_valid_d = '0;
    retire_entry_d = '0;
    if (i_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_d[i].valid    = 1'b0;
        entries_d[i].complete = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end else begin
      for (int unsigned p = 0; p < COMPLETE_W; p++) begin
        if (i_cmpl_valid[p] && entries_q[i_cmpl_idx[p]].valid) begin
          entries_d[i_cmpl_idx[p]].complete = 1'b1;
          entries_d[i_cmpl_idx[p]].data     = i_cmpl_data[p];
        end
      end
      for (int unsigned k = 0; k < RETIRE_W; k++) begin
        if (RCNT_W'(k) < ret_cnt) begin
          retire_valid_d[k]              = 1'b1;
          retire_entry_d[k]              = entries_q[ret_idx[k]];
          entries_d[ret_idx[k]].valid    = 1'b0;
          entries_d[ret_idx[k]].complete = 1'b0;
        end
      end
      head_d = head_q + PTR_W'(ret_cnt);
      if (o_alloc_ready) begin
        for (int unsigned k = 0; k < DISPATCH_W; k++) begin
          if (i_alloc_valid[k]) begin
            entries_d[o_alloc_idx[k]].alloc    = i_alloc_entry[k];
            entries_d[o_alloc_idx[k]].valid    = 1'b1;
            entries_d[o_alloc_idx[k]].complete = 1'b0;
            entries_d[o_alloc_idx[k]].data     = '0;
          end
        end
        tail_d = tail_q + alloc_cnt;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      entries_q      <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      retire_valid_q <= '0;
      retire_entry_q <= '0;
    end else begin
      entries_q      <= entries_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      retire_valid_q <= retire_valid_d;
      retire_entry_q <= retire_entry_d;
    end
  end

endmodule
